// File: rtl/complex_accumulator.sv
// ---------------------------------------------------------------------------
// complex_accumulator
//
// Sums VEC_LEN consecutive complex fp16 products (IEEE binary16 layout) into
// one complex dot-product result. Two combinational fp16 adders (real and
// imag) feed the accumulator registers, so one product is accepted per cycle.
// The finished sum is held on a valid/ready handshake until taken downstream.
//
// fp16 adder behaviour:
//   - exact two-operand sum, truncated toward zero to a 10-bit mantissa
//   - subnormal inputs read as zero; subnormal results flush to +0
//   - any exact-zero result is +0
//   - overflow saturates to +/- max finite
//   - Inf/NaN inputs read as +/- max finite
//   - an alignment shift of 12 or more returns the larger operand unchanged
//
// Ports:
//   CLK        clock, all state on the rising edge
//   rst        asynchronous reset, active low
//   in_valid   product present on in_real/in_imag
//   in_ready   block accepts a product this cycle (state ACC)
//   in_real    fp16 real part of product
//   in_imag    fp16 imag part of product
//   clear      synchronous abort: drop partial sum and any held result
//   out_valid  result valid (state HOLD)
//   out_ready  downstream accepts the result
//   out_real   fp16 accumulated real sum
//   out_imag   fp16 accumulated imag sum
//   busy       partial sum non-empty or a result is being held
// ---------------------------------------------------------------------------
module complex_accumulator #(
  parameter int VEC_LEN = 8,
  parameter int CNT_W   = 4
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_real,
  input  logic [15:0] in_imag,
  input  logic        clear,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_real,
  output logic [15:0] out_imag,
  output logic        busy
);

  typedef enum logic {ACC, HOLD} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] count;
  logic [15:0]      acc_real, acc_imag;
  logic [15:0]      sum_real, sum_imag;
  logic             take, last;

  // -------------------------------------------------------------------------
  // fp16 adder. Operands are ordered by magnitude so the subtraction path
  // never goes negative; the smaller operand is aligned into a field with
  // 11 guard bits so every shift below 12 stays exact before truncation.
  // -------------------------------------------------------------------------
  function automatic logic [15:0] fp16_add(input logic [15:0] a,
                                           input logic [15:0] b);
    logic [4:0]         ea, eb, el, es, diff, lead;
    logic [10:0]        ma, mb, ml, ms;
    logic               sl, ss, swap;
    logic [22:0]        xl, xs, sum;
    logic [9:0]         mant;
    logic signed [6:0]  e_res;
    logic [15:0]        res;

    // Inf/NaN become max finite, subnormals become zero (no hidden bit).
    ea = a[14:10];
    ma = {1'b1, a[9:0]};
    if (ea == 5'd31) begin
      ea = 5'd30;
      ma = 11'h7FF;
    end else if (ea == 5'd0) begin
      ma = 11'd0;
    end

    eb = b[14:10];
    mb = {1'b1, b[9:0]};
    if (eb == 5'd31) begin
      eb = 5'd30;
      mb = 11'h7FF;
    end else if (eb == 5'd0) begin
      mb = 11'd0;
    end

    swap = (eb > ea) || ((eb == ea) && (mb > ma));
    sl   = swap ? b[15] : a[15];
    el   = swap ? eb    : ea;
    ml   = swap ? mb    : ma;
    ss   = swap ? a[15] : b[15];
    es   = swap ? ea    : eb;
    ms   = swap ? ma    : mb;

    diff = el - es;
    xl   = {1'b0, ml, 11'd0};
    xs   = {1'b0, ms, 11'd0} >> diff;
    sum  = (sl == ss) ? (xl + xs) : (xl - xs);

    // Leading-one position; the hidden bit of the larger operand sits at 21.
    lead = 5'd0;
    for (int i = 0; i < 23; i++) begin
      if (sum[i]) lead = i[4:0];
    end

    // Move the leading one to bit 22 and keep the next ten bits (truncate).
    mant  = 10'((sum << (5'd22 - lead)) >> 12);
    e_res = $signed({2'b00, el}) + $signed({2'b00, lead}) - 7'sd21;

    if (diff >= 5'd12)        res = {sl, el, ml[9:0]};
    else if (sum == 23'd0)    res = 16'h0000;
    else if (e_res >= 7'sd31) res = {sl, 15'h7BFF};
    else if (e_res <= 7'sd0)  res = 16'h0000;
    else                      res = {sl, e_res[4:0], mant};
    return res;
  endfunction

  assign sum_real = fp16_add(acc_real, in_real);
  assign sum_imag = fp16_add(acc_imag, in_imag);

  assign take = in_valid && in_ready;
  assign last = (count == LAST_CNT);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) state <= ACC;
    else      state <= state_next;
  end

  // -------------------------------------------------------------------------
  // Next-state logic; clear overrides everything except reset.
  // -------------------------------------------------------------------------
  // NOTE: the default assignment first means every path assigns state_next,
  // so no latch is inferred.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = ACC;
    end else begin
      case (state)
        ACC:     if (take && last) state_next = HOLD;
        HOLD:    if (out_ready)    state_next = ACC;
        default: state_next = ACC;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs decoded from state
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state == ACC);
    out_valid = (state == HOLD);
    busy      = (count != '0) || (state == HOLD);
  end

  // -------------------------------------------------------------------------
  // Accumulator, element counter and result registers. In HOLD in_ready is
  // low, so take is low and the result registers stay stable.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      acc_real <= 16'h0000;
      acc_imag <= 16'h0000;
      out_real <= 16'h0000;
      out_imag <= 16'h0000;
    end else if (clear) begin
      count    <= '0;
      acc_real <= 16'h0000;
      acc_imag <= 16'h0000;
      out_real <= 16'h0000;
      out_imag <= 16'h0000;
    end else if (take) begin
      if (last) begin
        out_real <= sum_real;
        out_imag <= sum_imag;
        acc_real <= 16'h0000;
        acc_imag <= 16'h0000;
        count    <= '0;
      end else begin
        acc_real <= sum_real;
        acc_imag <= sum_imag;
        count    <= count + 1'b1;
      end
    end
  end

endmodule
